// File: rtl/wb_dram_arbiter.sv
// wb_dram_arbiter: round-robin Wishbone arbiter sharing the DRAM controller slave port
module wb_dram_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int WORD_SIZE   = 128,
    parameter int MAX_BEATS   = 8
) (
    input  logic                           user_clk_i,
    input  logic                           rst_i,
    input  logic [NUM_MASTERS-1:0]         m_cyc_i,
    input  logic [NUM_MASTERS-1:0]         m_stb_i,
    input  logic [NUM_MASTERS-1:0]         m_we_i,
    input  logic [NUM_MASTERS*32-1:0]      m_addr_i,
    input  logic [NUM_MASTERS*WORD_SIZE-1:0] m_data_i,
    output logic [WORD_SIZE-1:0]           m_data_o,
    output logic [NUM_MASTERS-1:0]         m_ack_o,
    output logic                           s_cyc_o,
    output logic                           s_stb_o,
    output logic                           s_we_o,
    output logic [31:0]                    s_addr_o,
    output logic [WORD_SIZE-1:0]           s_data_o,
    input  logic [WORD_SIZE-1:0]           s_data_i,
    input  logic                           s_ack_i,
    output logic [NUM_MASTERS-1:0]         gnt_o
);
    localparam int IW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t                 state, state_nxt;
    logic [IW-1:0]          gnt_idx, rr_ptr, pick_idx, cand;
    logic                   pick_vld, granted, limit_hit;
    logic [7:0]             beat_cnt;
    logic                   ack_q;
    logic [NUM_MASTERS-1:0] req;

    assign req       = m_cyc_i & m_stb_i;
    assign granted   = state == GRANT;
    assign limit_hit = beat_cnt == 8'(MAX_BEATS);

    // Rotating-priority search: scan downward so the requester closest to rr_ptr wins last
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            cand = IW'((int'(rr_ptr) + i) % NUM_MASTERS);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Next state: release on cyc drop, or between beats once the beat budget is spent
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = pick_vld ? GRANT : IDLE;
            GRANT:   state_nxt = (!m_cyc_i[gnt_idx] || (limit_hit && !s_ack_i && !m_stb_i[gnt_idx])) ? RELEASE : GRANT;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Straight-through mux of the granted master; strobes gated off outside GRANT
    always_comb begin
        s_cyc_o  = granted & m_cyc_i[gnt_idx];
        s_stb_o  = granted & m_stb_i[gnt_idx];
        s_we_o   = granted & m_we_i[gnt_idx];
        s_addr_o = m_addr_i[32*int'(gnt_idx) +: 32];
        s_data_o = m_data_i[WORD_SIZE*int'(gnt_idx) +: WORD_SIZE];
        m_data_o = s_data_i;
        m_ack_o  = granted ? (NUM_MASTERS'(s_ack_i) << gnt_idx) : '0;
        gnt_o    = granted ? (NUM_MASTERS'(1) << gnt_idx) : '0;
    end

    // State, grant index, round-robin pointer and beat counter
    always_ff @(posedge user_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            ack_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            ack_q <= s_ack_i;
            if (state == IDLE && pick_vld) begin
                gnt_idx  <= pick_idx;
                beat_cnt <= '0;
            end else if (granted && s_ack_i && !ack_q && !limit_hit) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (state == RELEASE)
                rr_ptr <= (gnt_idx == IW'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_dram_arbiter.sv
// tb_wb_dram_arbiter: scenario tasks with a grant/data scoreboard for wb_dram_arbiter
module tb_wb_dram_arbiter;
    localparam int N = 4;
    localparam int W = 128;
    localparam logic [W-1:0] A5   = {16{8'hA5}};
    localparam logic [W-1:0] DEAD = {4{32'hDEADBEEF}};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N*32-1:0] m_addr = '0;
    logic [N*W-1:0] m_wdata = '0;
    logic [W-1:0]   m_rdata, s_wdata;
    logic [W-1:0]   s_rdata = '0;
    logic [N-1:0]   m_ack, gnt;
    logic           s_cyc, s_stb, s_we;
    logic           s_ack = 1'b0;
    logic [31:0]    s_addr;

    int checks = 0;
    int fails  = 0;
    int exp_gnt[$];
    logic [W-1:0] exp_data[$];

    always #5 clk = ~clk;

    wb_dram_arbiter #(.NUM_MASTERS(N), .WORD_SIZE(W), .MAX_BEATS(2)) dut (
        .user_clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_data_i(m_wdata),
        .m_data_o(m_rdata), .m_ack_o(m_ack),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_addr_o(s_addr), .s_data_o(s_wdata),
        .s_data_i(s_rdata), .s_ack_i(s_ack),
        .gnt_o(gnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input bit we, input logic [31:0] a, input logic [W-1:0] d);
        m_cyc[k] = 1'b1;
        m_stb[k] = 1'b1;
        m_we[k]  = we;
        m_addr[32*k +: 32] = a;
        m_wdata[W*k +: W]  = d;
    endtask

    task automatic drop(input int k);
        m_cyc[k] = 1'b0;
        m_stb[k] = 1'b0;
    endtask

    // Wait for a nonzero grant; gap counts sampled idle cycles before it appeared
    task automatic wait_gnt(output int idx, output bit to, output int gap);
        to  = 1'b1;
        gap = 0;
        idx = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                to = 1'b0;
                break;
            end
            gap++;
        end
        for (int i = 0; i < N; i++)
            if (gnt[i]) idx = i;
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt == '0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // One slave beat: ack held until the master drops stb, then optionally restrobe
    task automatic do_beat(input int k, input logic [W-1:0] rd, input bit restb,
                           output logic [N-1:0] ack_seen, output logic [W-1:0] data_seen);
        s_rdata = rd;
        s_ack   = 1'b1;
        #1;
        ack_seen  = m_ack;
        data_seen = m_rdata;
        tick();
        s_ack    = 1'b0;
        m_stb[k] = 1'b0;
        tick();
        if (restb) m_stb[k] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_cyc = '1;
        m_stb = '1;
        m_we  = '1;
        m_addr[31:0] = 32'h40;
        m_wdata[W-1:0] = A5;
        s_rdata = DEAD;
        s_ack = 1'b1;
        repeat (2) tick();
        checks++; if (gnt !== '0) begin fails++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0); end
        checks++; if (m_ack !== '0) begin fails++; $display("FAIL reset_ack: got %b expected %b", m_ack, 4'b0); end
        checks++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin fails++; $display("FAIL reset_strobes: got %b expected 000", {s_cyc, s_stb, s_we}); end
        checks++; if (s_addr !== 32'h40) begin fails++; $display("FAIL reset_addr_mux: got %h expected %h", s_addr, 32'h40); end
        checks++; if (s_wdata !== A5) begin fails++; $display("FAIL reset_data_mux: got %h expected %h", s_wdata, A5); end
        checks++; if (m_rdata !== DEAD) begin fails++; $display("FAIL reset_rdata: got %h expected %h", m_rdata, DEAD); end
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        s_ack = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (gnt !== '0) begin fails++; $display("FAIL idle_gnt: got %b expected %b", gnt, 4'b0); end
    endtask

    task automatic test_single();
        logic [N-1:0] ack;
        logic [W-1:0] d;
        bit to;
        drive(2, 1'b1, 32'h100, A5);
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin fails++; $display("FAIL single_latency: got %b expected %b", gnt, 4'b0000); end
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin fails++; $display("FAIL single_gnt: got %b expected %b", gnt, 4'b0100); end
        checks++; if ({s_cyc, s_stb, s_we} !== 3'b111) begin fails++; $display("FAIL single_strobes: got %b expected 111", {s_cyc, s_stb, s_we}); end
        checks++; if (s_addr !== 32'h100) begin fails++; $display("FAIL single_addr: got %h expected %h", s_addr, 32'h100); end
        checks++; if (s_wdata !== A5) begin fails++; $display("FAIL single_wdata: got %h expected %h", s_wdata, A5); end
        do_beat(2, '0, 1'b0, ack, d);
        checks++; if (ack !== 4'b0100) begin fails++; $display("FAIL single_ack: got %b expected %b", ack, 4'b0100); end
        drop(2);
        @(negedge clk);
        checks++; if (s_cyc !== 1'b0 || gnt !== 4'b0100) begin fails++; $display("FAIL single_cyc_drop: got cyc=%b gnt=%b expected cyc=0 gnt=0100", s_cyc, gnt); end
        wait_idle(to);
        checks++; if (to) begin fails++; $display("FAIL single_release: got gnt=%b expected 0000", gnt); end
    endtask

    task automatic test_wrap();
        logic [N-1:0] ack;
        logic [W-1:0] d;
        int idx, gap, e;
        bit to;
        drive(1, 1'b0, 32'h1100, '0);
        drive(3, 1'b0, 32'h3300, '0);
        exp_gnt.push_back(3);
        exp_gnt.push_back(1);
        for (int n = 0; n < 2; n++) begin
            wait_gnt(idx, to, gap);
            e = exp_gnt.pop_front();
            checks++; if (to || idx != e) begin fails++; $display("FAIL wrap_order: got %0d expected %0d", idx, e); end
            if (n == 1) begin
                checks++; if (gap + 1 != 2) begin fails++; $display("FAIL wrap_gap: got %0d expected %0d", gap + 1, 2); end
            end
            if (to) return;
            do_beat(idx, DEAD ^ W'(idx), 1'b0, ack, d);
            checks++; if (ack !== 4'(1 << idx)) begin fails++; $display("FAIL wrap_ack: got %b expected %b", ack, 4'(1 << idx)); end
            checks++; if (d !== (DEAD ^ W'(idx))) begin fails++; $display("FAIL wrap_rdata: got %h expected %h", d, DEAD ^ W'(idx)); end
            drop(idx);
            wait_idle(to);
        end
    endtask

    task automatic test_order_after_reset();
        logic [N-1:0] ack;
        logic [W-1:0] d, ed;
        int idx, gap, e;
        bit to;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 1'b0, 32'h200, '0);
        drive(3, 1'b0, 32'h300, '0);
        exp_gnt.push_back(0);
        exp_gnt.push_back(3);
        exp_data.push_back(DEAD);
        exp_data.push_back(~DEAD);
        for (int n = 0; n < 2; n++) begin
            wait_gnt(idx, to, gap);
            e = exp_gnt.pop_front();
            ed = exp_data.pop_front();
            checks++; if (to || idx != e) begin fails++; $display("FAIL rst_order: got %0d expected %0d", idx, e); end
            if (to) return;
            checks++; if (s_addr !== (e == 0 ? 32'h200 : 32'h300) || s_we !== 1'b0) begin fails++; $display("FAIL rst_order_addr: got %h we=%b expected %h we=0", s_addr, s_we, e == 0 ? 32'h200 : 32'h300); end
            do_beat(idx, ed, 1'b0, ack, d);
            checks++; if (d !== ed) begin fails++; $display("FAIL rst_order_rdata: got %h expected %h", d, ed); end
            drop(idx);
            wait_idle(to);
        end
    endtask

    task automatic test_ack_isolation();
        int idx, gap;
        bit to;
        drive(1, 1'b0, 32'h10, '0);
        drive(2, 1'b0, 32'h20, '0);
        wait_gnt(idx, to, gap);
        checks++; if (to || idx != 1) begin fails++; $display("FAIL iso_gnt: got %0d expected %0d", idx, 1); end
        for (int p = 0; p < 3; p++) begin
            s_ack = 1'b1;
            #1;
            checks++; if (m_ack !== 4'b0010 || gnt !== 4'b0010) begin fails++; $display("FAIL iso_ack_high: got ack=%b gnt=%b expected 0010", m_ack, gnt); end
            tick();
            s_ack = 1'b0;
            #1;
            checks++; if (m_ack !== 4'b0000) begin fails++; $display("FAIL iso_ack_low: got %b expected %b", m_ack, 4'b0000); end
            tick();
        end
        drop(1);
        wait_idle(to);
        wait_gnt(idx, to, gap);
        checks++; if (to || idx != 2) begin fails++; $display("FAIL iso_next: got %0d expected %0d", idx, 2); end
        drop(2);
        wait_idle(to);
    endtask

    task automatic test_beat_limit();
        logic [N-1:0] ack;
        logic [W-1:0] d;
        int idx, gap, e, rem, nb;
        bit to;
        rem = 5;
        drive(0, 1'b0, 32'h400, '0);
        drive(1, 1'b0, 32'h500, '0);
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        exp_gnt.push_back(0);
        exp_gnt.push_back(0);
        for (int g = 0; g < 4; g++) begin
            wait_idle(to);
            wait_gnt(idx, to, gap);
            e = exp_gnt.pop_front();
            checks++; if (to || idx != e) begin fails++; $display("FAIL limit_order: grant %0d got %0d expected %0d", g, idx, e); end
            if (to) return;
            nb = (idx == 0) ? ((rem < 2) ? rem : 2) : 1;
            for (int b = 0; b < nb; b++) begin
                do_beat(idx, DEAD + W'(g * 4 + b), idx == 0, ack, d);
                checks++; if (ack !== 4'(1 << idx) || d !== DEAD + W'(g * 4 + b)) begin fails++; $display("FAIL limit_beat: got ack=%b data=%h expected ack=%b data=%h", ack, d, 4'(1 << idx), DEAD + W'(g * 4 + b)); end
            end
            if (idx == 0) rem -= nb;
            if (idx != 0 || rem == 0) drop(idx);
        end
        wait_idle(to);
        checks++; if (to || m_cyc !== '0) begin fails++; $display("FAIL limit_done: got gnt=%b cyc=%b expected 0000", gnt, m_cyc); end
    endtask

    task automatic test_reset_mid_grant();
        int idx, gap;
        bit to;
        drive(2, 1'b1, 32'h600, A5);
        wait_gnt(idx, to, gap);
        checks++; if (to || idx != 2 || s_stb !== 1'b1) begin fails++; $display("FAIL mid_gnt: got %0d stb=%b expected 2 stb=1", idx, s_stb); end
        drive(0, 1'b0, 32'h700, '0);
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack !== 4'b0100) begin fails++; $display("FAIL mid_ack: got %b expected %b", m_ack, 4'b0100); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (s_cyc !== 1'b0 || gnt !== '0 || m_ack !== '0) begin fails++; $display("FAIL mid_async: got cyc=%b gnt=%b ack=%b expected all zero", s_cyc, gnt, m_ack); end
        s_ack = 1'b0;
        tick();
        rst = 1'b0;
        wait_gnt(idx, to, gap);
        checks++; if (to || idx != 0) begin fails++; $display("FAIL mid_after_reset: got %0d expected %0d", idx, 0); end
        drop(0);
        drop(2);
        wait_idle(to);
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_order_after_reset();
        test_ack_isolation();
        test_beat_limit();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/wb_dram_arbiter.md
# wb_dram_arbiter

Round-robin Wishbone arbiter that shares the single Wishbone slave port of the DRAM controller among `NUM_MASTERS` requesters (CPU data port, DMA, video fetch, etc.) in the user clock domain. It grants one master at a time, holds the grant for the whole Wishbone cycle (`cyc`), and enforces fairness with a per-grant beat limit. It contains no data buffering: the granted master is connected straight through to the DRAM controller port.

## Interface
- `NUM_MASTERS`, 4: number of requesters, 2..8.
- `WORD_SIZE`, 128: data width, equal to the DRAM controller word.
- `MAX_BEATS`, 8: acked beats allowed per grant before forced re-arbitration, 1..255.

- `user_clk_i`  in  1  system clock; all logic on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `m_cyc_i`  in  NUM_MASTERS  per-master Wishbone cyc.
- `m_stb_i`  in  NUM_MASTERS  per-master stb.
- `m_we_i`  in  NUM_MASTERS  per-master we.
- `m_addr_i`  in  NUM_MASTERS*32  packed addresses; master k at [32k+31:32k].
- `m_data_i`  in  NUM_MASTERS*WORD_SIZE  packed write data.
- `m_data_o`  out  WORD_SIZE  read data, shared by all masters.
- `m_ack_o`  out  NUM_MASTERS  per-master ack.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to DRAM controller.
- `s_addr_o`  out  32  to DRAM controller.
- `s_data_o`  out  WORD_SIZE  to DRAM controller.
- `s_data_i`  in  WORD_SIZE  from DRAM controller.
- `s_ack_i`  in  1  from DRAM controller; held high until stb drops.
- `gnt_o`  out  NUM_MASTERS  one-hot current grant, all zero when idle.

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE: `s_cyc_o`=`s_stb_o`=0. When any `m_cyc_i[k] & m_stb_i[k]` is set, pick the first requester at or after `rr_ptr`, searching upward and wrapping modulo NUM_MASTERS. Register the grant index, clear `beat_cnt`, go to GRANT.
- GRANT: the slave port outputs are a combinational mux of the granted master's inputs. `m_ack_o[g]`=`s_ack_i`; all other acks are 0. `m_data_o`=`s_data_i` at all times.
- `beat_cnt` (8 bits) increments on each rising edge of `s_ack_i`, detected against a registered copy `ack_q`. It saturates at MAX_BEATS.
- GRANT -> RELEASE when either:
  - `m_cyc_i[g]`=0, or
  - `beat_cnt`==MAX_BEATS and `s_ack_i`=0 and `m_stb_i[g]`=0, so the release falls between beats and never splits an acked beat.
- RELEASE: one cycle with `s_cyc_o`=0. Set `rr_ptr` = (g+1) mod NUM_MASTERS, go to IDLE.
- Forced release with `cyc` still high: master g remains a requester and is served again after higher-priority masters under the new `rr_ptr`.
- Grant changes only on the IDLE->GRANT transition. A request arriving mid-grant waits.
- A master dropping `stb` while keeping `cyc` keeps its grant (beat limit aside).
- Reset: state IDLE, `rr_ptr`=0, grant index 0, `beat_cnt`=0, `ack_q`=0. As a result `gnt_o`=0, all `m_ack_o`=0, and `s_cyc_o`=`s_stb_o`=`s_we_o`=0. `s_addr_o`, `s_data_o`, `m_data_o` follow the mux with master 0 selected (`m_data_o`=`s_data_i`).
- Reset asserted mid-grant drops `s_cyc_o` immediately (asynchronous). The DRAM controller is reset by the same source.

## Timing
- Grant latency: request sampled in IDLE at edge N; `s_cyc_o`/`s_stb_o` high after edge N, i.e. 1 cycle after request.
- Ack path: `s_ack_i` -> `m_ack_o[g]` combinational, zero latency.
- `s_data_i` -> `m_data_o` combinational.
- Minimum gap between grants: 2 cycles with `s_cyc_o` low (RELEASE + IDLE).
- Back-to-back turnaround: last ack, then master drops stb/cyc, then RELEASE, IDLE, GRANT of next master. New `s_stb_o` appears at the earliest 2 cycles after the previous master's `cyc` falls.
- Simultaneous requests in IDLE are resolved in the same cycle by `rr_ptr` order; there are no ties.

## Test plan
- Single master: master 2 writes addr 0x100, data 0xA5.. -> `gnt_o`=0b0100 one cycle later; `s_addr_o`=0x100; `m_ack_o`=0b0100 while `s_ack_i`=1; master 2 drops cyc -> RELEASE, then `rr_ptr`=3.
- After reset, masters 0 and 3 both request reads -> master 0 granted first; after it releases, master 3 granted. `m_data_o` carries `s_data_i`=0xDEAD_BEEF.. for each read.
- Round-robin wrap: `rr_ptr`=3, masters 1 and 3 requesting -> grant 3, then 1; `rr_ptr` ends at 2.
- Beat limit with MAX_BEATS=2: master 0 holds cyc for 5 reads, master 1 requesting -> after the 2nd ack completes and stb drops, grant moves to master 1. Master 0 is regranted only after master 1 releases.
- Ack isolation: during a grant to master 1, `s_ack_i` pulses -> only `m_ack_o[1]` toggles; `m_ack_o[0,2,3]` stay 0.
- Reset mid-grant: assert `rst_i` while `s_stb_o`=1 -> `s_cyc_o`=0, `gnt_o`=0 immediately. After deassert, master 0 wins if requesting.
